// File: rtl/div_issue_if.sv
// Bundle of the three handshake groups around the divider issue stage:
// request port, held operands / start / completion towards the divider,
// and the response port. The stage connects through the slave modport;
// the surrounding environment (requester, divider, consumer) uses master.
interface div_issue_if #(
    parameter int parallelism = 32,
    parameter int CYC_W       = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_usigned;
    logic [parallelism-1:0] req_dividend;
    logic [parallelism-1:0] req_divisor;

    logic                   div_start;
    logic                   div_usigned;
    logic [parallelism-1:0] div_dividend;
    logic [parallelism-1:0] div_divisor;
    logic                   div_done;
    logic [parallelism-1:0] div_quotient;
    logic [parallelism-1:0] div_reminder;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [parallelism-1:0] rsp_quotient;
    logic [parallelism-1:0] rsp_reminder;
    logic                   rsp_div0;
    logic                   rsp_ovf;
    logic [CYC_W-1:0]       rsp_cycles;

    modport slave (
        input  req_valid, req_usigned, req_dividend, req_divisor,
        input  div_done, div_quotient, div_reminder,
        input  rsp_ready,
        output req_ready,
        output div_start, div_usigned, div_dividend, div_divisor,
        output rsp_valid, rsp_quotient, rsp_reminder, rsp_div0, rsp_ovf, rsp_cycles
    );

    modport master (
        output req_valid, req_usigned, req_dividend, req_divisor,
        output div_done, div_quotient, div_reminder,
        output rsp_ready,
        input  req_ready,
        input  div_start, div_usigned, div_dividend, div_divisor,
        input  rsp_valid, rsp_quotient, rsp_reminder, rsp_div0, rsp_ovf, rsp_cycles
    );
endinterface

// File: rtl/div_issue_stage.sv
// Divider issue stage: accepts one divide request, resolves divide-by-zero
// and signed MIN/-1 overflow locally, otherwise holds the operands, pulses
// div_start and waits for div_done, then presents the result with the
// number of cycles spent waiting (saturating) on a valid/ready response port.
module div_issue_stage #(
    parameter int parallelism = 32,
    parameter int CYC_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    div_issue_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [parallelism-1:0] ALL_ONES = {parallelism{1'b1}};
    localparam logic [parallelism-1:0] ZERO_W   = {parallelism{1'b0}};
    localparam logic [parallelism-1:0] MIN_NEG  = {1'b1, {(parallelism-1){1'b0}}};
    localparam logic [CYC_W-1:0]       CYC_MAX  = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0]       CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0]       CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

    state_t                 state_r;
    logic                   div_start_r;
    logic                   div_usigned_r;
    logic [parallelism-1:0] div_dividend_r;
    logic [parallelism-1:0] div_divisor_r;
    logic                   rsp_valid_r;
    logic [parallelism-1:0] rsp_quotient_r;
    logic [parallelism-1:0] rsp_reminder_r;
    logic                   rsp_div0_r;
    logic                   rsp_ovf_r;
    logic [CYC_W-1:0]       rsp_cycles_r;

    logic                   is_div0_s;
    logic                   is_ovf_s;
    logic [CYC_W-1:0]       cycles_inc_s;

    // Classify the incoming request straight from the request inputs.
    always_comb begin
        is_div0_s = 1'b0;
        is_ovf_s  = 1'b0;
        if (bus.req_divisor == ZERO_W) begin
            is_div0_s = 1'b1;
        end else if (!bus.req_usigned && (bus.req_dividend == MIN_NEG) &&
                     (bus.req_divisor == ALL_ONES)) begin
            is_ovf_s = 1'b1;
        end else begin
            is_ovf_s = 1'b0;
        end
    end

    // Saturating next value of the wait-cycle counter.
    always_comb begin
        cycles_inc_s = rsp_cycles_r;
        if (rsp_cycles_r == CYC_MAX) begin
            cycles_inc_s = rsp_cycles_r;
        end else begin
            cycles_inc_s = rsp_cycles_r + CYC_ONE;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            div_start_r    <= 1'b0;
            div_usigned_r  <= 1'b0;
            div_dividend_r <= ZERO_W;
            div_divisor_r  <= ZERO_W;
            rsp_valid_r    <= 1'b0;
            rsp_quotient_r <= ZERO_W;
            rsp_reminder_r <= ZERO_W;
            rsp_div0_r     <= 1'b0;
            rsp_ovf_r      <= 1'b0;
            rsp_cycles_r   <= CYC_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        div_usigned_r  <= bus.req_usigned;
                        div_dividend_r <= bus.req_dividend;
                        div_divisor_r  <= bus.req_divisor;
                        if (is_div0_s) begin
                            rsp_quotient_r <= ALL_ONES;
                            rsp_reminder_r <= bus.req_dividend;
                            rsp_div0_r     <= 1'b1;
                            rsp_ovf_r      <= 1'b0;
                            rsp_cycles_r   <= CYC_ZERO;
                            rsp_valid_r    <= 1'b1;
                            state_r        <= RESP;
                        end else if (is_ovf_s) begin
                            rsp_quotient_r <= bus.req_dividend;
                            rsp_reminder_r <= ZERO_W;
                            rsp_div0_r     <= 1'b0;
                            rsp_ovf_r      <= 1'b1;
                            rsp_cycles_r   <= CYC_ZERO;
                            rsp_valid_r    <= 1'b1;
                            state_r        <= RESP;
                        end else begin
                            div_start_r    <= 1'b1;
                            state_r        <= ISSUE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    div_start_r  <= 1'b0;
                    rsp_cycles_r <= CYC_ZERO;
                    state_r      <= WAIT;
                end
                WAIT: begin
                    // The completion cycle itself is counted.
                    rsp_cycles_r <= cycles_inc_s;
                    if (bus.div_done) begin
                        rsp_quotient_r <= bus.div_quotient;
                        rsp_reminder_r <= bus.div_reminder;
                        rsp_div0_r     <= 1'b0;
                        rsp_ovf_r      <= 1'b0;
                        rsp_valid_r    <= 1'b1;
                        state_r        <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    div_start_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state_r == IDLE);
    assign bus.div_start    = div_start_r;
    assign bus.div_usigned  = div_usigned_r;
    assign bus.div_dividend = div_dividend_r;
    assign bus.div_divisor  = div_divisor_r;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_quotient = rsp_quotient_r;
    assign bus.rsp_reminder = rsp_reminder_r;
    assign bus.rsp_div0     = rsp_div0_r;
    assign bus.rsp_ovf      = rsp_ovf_r;
    assign bus.rsp_cycles   = rsp_cycles_r;

endmodule

// File: tb/tb_div_issue_stage.sv
// Bench for div_issue_stage. Two instances (CYC_W = 8 and CYC_W = 4) see
// identical stimulus; the bench plays requester, divider and consumer.
// Expected responses come from a plain-arithmetic model of the divide rules.
module tb_div_issue_stage;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         req_valid;
    logic         req_usigned;
    logic [W-1:0] req_dividend;
    logic [W-1:0] req_divisor;
    logic         div_done;
    logic [W-1:0] div_quotient;
    logic [W-1:0] div_reminder;
    logic         rsp_ready;

    int checks   = 0;
    int failures = 0;

    div_issue_if #(.parallelism(W), .CYC_W(8)) bus8 ();
    div_issue_if #(.parallelism(W), .CYC_W(4)) bus4 ();

    assign bus8.req_valid    = req_valid;
    assign bus8.req_usigned  = req_usigned;
    assign bus8.req_dividend = req_dividend;
    assign bus8.req_divisor  = req_divisor;
    assign bus8.div_done     = div_done;
    assign bus8.div_quotient = div_quotient;
    assign bus8.div_reminder = div_reminder;
    assign bus8.rsp_ready    = rsp_ready;
    assign bus4.req_valid    = req_valid;
    assign bus4.req_usigned  = req_usigned;
    assign bus4.req_dividend = req_dividend;
    assign bus4.req_divisor  = req_divisor;
    assign bus4.div_done     = div_done;
    assign bus4.div_quotient = div_quotient;
    assign bus4.div_reminder = div_reminder;
    assign bus4.rsp_ready    = rsp_ready;

    div_issue_stage #(.parallelism(W), .CYC_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    div_issue_stage #(.parallelism(W), .CYC_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the response must be for a given request.
    task automatic model(input logic usg, input logic [W-1:0] dd, input logic [W-1:0] dv,
                         output bit special, output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic d0, output logic ov);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = dd;
        sb = dv;
        special = 1'b0; d0 = 1'b0; ov = 1'b0;
        if (dv == 32'd0) begin
            special = 1'b1; d0 = 1'b1; q = 32'hFFFF_FFFF; r = dd;
        end else if (!usg && dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
            special = 1'b1; ov = 1'b1; q = dd; r = 32'd0;
        end else if (usg) begin
            q = dd / dv; r = dd % dv;
        end else begin
            q = sa / sb; r = sa % sb;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_rdy8"}, {31'd0, bus8.req_ready}, 32'd1);
        chk({tag, "_rdy4"}, {31'd0, bus4.req_ready}, 32'd1);
        chk({tag, "_start"}, {31'd0, bus8.div_start | bus4.div_start}, 32'd0);
        chk({tag, "_dusg"}, {31'd0, bus8.div_usigned | bus4.div_usigned}, 32'd0);
        chk({tag, "_ddd"}, bus8.div_dividend | bus4.div_dividend, 32'd0);
        chk({tag, "_ddv"}, bus8.div_divisor | bus4.div_divisor, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, bus8.rsp_valid | bus4.rsp_valid}, 32'd0);
        chk({tag, "_rq"}, bus8.rsp_quotient | bus4.rsp_quotient, 32'd0);
        chk({tag, "_rr"}, bus8.rsp_reminder | bus4.rsp_reminder, 32'd0);
        chk({tag, "_flags"}, {30'd0, bus8.rsp_div0 | bus4.rsp_div0, bus8.rsp_ovf | bus4.rsp_ovf}, 32'd0);
        chk({tag, "_cyc"}, {24'd0, bus8.rsp_cycles} | {28'd0, bus4.rsp_cycles}, 32'd0);
    endtask

    task automatic check_rsp(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic d0, input logic ov, input int c8, input int c4);
        chk({tag, "_valid8"}, {31'd0, bus8.rsp_valid}, 32'd1);
        chk({tag, "_valid4"}, {31'd0, bus4.rsp_valid}, 32'd1);
        chk({tag, "_q8"}, bus8.rsp_quotient, q);
        chk({tag, "_r8"}, bus8.rsp_reminder, r);
        chk({tag, "_q4"}, bus4.rsp_quotient, q);
        chk({tag, "_r4"}, bus4.rsp_reminder, r);
        chk({tag, "_div0"}, {31'd0, bus8.rsp_div0}, {31'd0, d0});
        chk({tag, "_ovf"}, {31'd0, bus8.rsp_ovf}, {31'd0, ov});
        chk({tag, "_div0_4"}, {31'd0, bus4.rsp_div0}, {31'd0, d0});
        chk({tag, "_ovf_4"}, {31'd0, bus4.rsp_ovf}, {31'd0, ov});
        chk({tag, "_cyc8"}, {24'd0, bus8.rsp_cycles}, c8);
        chk({tag, "_cyc4"}, {28'd0, bus4.rsp_cycles}, c4);
        chk({tag, "_rdy"}, {31'd0, bus8.req_ready | bus4.req_ready}, 32'd0);
    endtask

    // One full transaction; entered and left just after a falling edge.
    task automatic run_txn(input string tag, input logic usg, input logic [W-1:0] dd,
                           input logic [W-1:0] dv, input int n, input int hold);
        bit           special;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         d0;
        logic         ov;
        int           c8;
        int           c4;
        model(usg, dd, dv, special, q, r, d0, ov);
        chk({tag, "_accept_rdy"}, {30'd0, bus8.req_ready, bus4.req_ready}, 32'd3);
        req_valid = 1'b1; req_usigned = usg; req_dividend = dd; req_divisor = dv;
        @(negedge clk);
        req_valid = 1'b0; req_usigned = $urandom; req_dividend = $urandom; req_divisor = $urandom;
        chk({tag, "_hold_dd"}, bus8.div_dividend, dd);
        chk({tag, "_hold_dv"}, bus8.div_divisor, dv);
        chk({tag, "_hold_usg"}, {31'd0, bus8.div_usigned}, {31'd0, usg});
        chk({tag, "_hold_dd4"}, bus4.div_dividend, dd);
        if (special) begin
            chk({tag, "_no_start"}, {31'd0, bus8.div_start | bus4.div_start}, 32'd0);
            c8 = 0; c4 = 0;
        end else begin
            chk({tag, "_start"}, {30'd0, bus8.div_start, bus4.div_start}, 32'd3);
            chk({tag, "_issue_valid"}, {31'd0, bus8.rsp_valid}, 32'd0);
            chk({tag, "_issue_rdy"}, {31'd0, bus8.req_ready}, 32'd0);
            for (int k = 1; k <= n; k++) begin
                @(negedge clk);
                chk({tag, "_wait_start"}, {31'd0, bus8.div_start | bus4.div_start}, 32'd0);
                chk({tag, "_wait_rdy"}, {31'd0, bus8.req_ready | bus4.req_ready}, 32'd0);
                chk({tag, "_wait_valid"}, {31'd0, bus8.rsp_valid | bus4.rsp_valid}, 32'd0);
                if (k == n) begin
                    div_done = 1'b1; div_quotient = q; div_reminder = r;
                end
            end
            @(negedge clk);
            div_done = 1'b0; div_quotient = $urandom; div_reminder = $urandom;
            c8 = (n > 255) ? 255 : n;
            c4 = (n > 15) ? 15 : n;
        end
        check_rsp(tag, q, r, d0, ov, c8, c4);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check_rsp({tag, "_bp"}, q, r, d0, ov, c8, c4);
            chk({tag, "_bp_dd"}, bus8.div_dividend, dd);
            chk({tag, "_bp_start"}, {31'd0, bus8.div_start | bus4.div_start}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_drop_valid"}, {31'd0, bus8.rsp_valid | bus4.rsp_valid}, 32'd0);
        chk({tag, "_idle_rdy"}, {30'd0, bus8.req_ready, bus4.req_ready}, 32'd3);
        chk({tag, "_held_q"}, bus8.rsp_quotient, q);
        chk({tag, "_held_r"}, bus4.rsp_reminder, r);
    endtask

    initial begin
        logic         usg;
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        int           sel;

        req_valid = 1'b0; req_usigned = 1'b0; req_dividend = '0; req_divisor = '0;
        div_done = 1'b0; div_quotient = '0; div_reminder = '0; rsp_ready = 1'b0;

        // Reset values.
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");

        // rsp_ready with no response pending does nothing.
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        check_idle_zero("stray_ready");

        // Directed cases.
        run_txn("udiv_100_7", 1'b1, 32'd100, 32'd7, 34, 0);
        run_txn("sdiv0", 1'b0, 32'hFFFF_FFF9, 32'd0, 0, 0);
        run_txn("sovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        run_txn("u_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0);
        run_txn("bp_sdiv", 1'b0, 32'hFFFF_FF9C, 32'd7, 5, 5);
        run_txn("bp_div0", 1'b1, 32'd12345, 32'd0, 0, 5);
        run_txn("sat", 1'b1, 32'd1000, 32'd3, 20, 0);
        run_txn("wait1", 1'b0, 32'd7, 32'hFFFF_FFFE, 1, 2);

        // Reset while the divider is busy; the late completion must be dropped.
        req_valid = 1'b1; req_usigned = 1'b1; req_dividend = 32'd50; req_divisor = 32'd5;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_start", {31'd0, bus8.div_start}, 32'd1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        div_done = 1'b1; div_quotient = 32'd10; div_reminder = 32'd0;
        @(negedge clk);
        div_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_idle_zero("rst_late_done");
            @(negedge clk);
        end

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            usg = $urandom_range(0, 1);
            dd  = $urandom;
            dv  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                dv = 32'd0;
            end else if (sel == 1) begin
                dd = 32'h8000_0000; dv = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                dv = $urandom_range(1, 9);
            end
            run_txn("rand", usg, dd, dv, $urandom_range(1, 40), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
